// File: rtl/mf_disp_cmd_tx.sv
// mf_disp_cmd_tx: source-side issuer for the 4-bit display command nibble path.
// Buffers producer commands in a small FIFO and emits each as a single-cycle
// nonzero pulse toward the CDC stage, pacing issue with a credit counter and
// an optional minimum idle gap between pulses.
module mf_disp_cmd_tx #(
   parameter int DEPTH   = 4,   // queue entries, power of 2, >= 2
   parameter int CREDITS = 16,  // downstream FIFO depth, 1..255
   parameter int GAP     = 1    // idle cycles between pulses, 0..15
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cmd_valid,
   input  logic [3:0] cmd_data,
   output logic       cmd_ready,
   input  logic       flush,
   input  logic       credit_ret,
   output logic [3:0] pulse_out,
   output logic [7:0] credits,
   output logic       busy,
   output logic       err_zero,
   output logic       err_credit
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [7:0]     CRED_MAX = 8'(CREDITS);
   localparam logic [3:0]     GAP_LD   = 4'(GAP);

   typedef enum logic {ST_READY, ST_GAP} state_t;

   logic [3:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic [3:0]    r_pulse;
   logic [7:0]    r_cred;
   logic [3:0]    r_gapc;
   logic          r_ez, r_ec;
   state_t        r_state;

   state_t        w_state_nxt;
   logic [3:0]    w_gapc_nxt;
   logic          w_issue, w_hs, w_push, w_empty;

   // Handshake is qualified by registered occupancy only; zero nibbles and
   // flush cycles still handshake but never reach the queue.
   assign cmd_ready = (r_count != FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign w_hs      = cmd_valid & cmd_ready;
   assign w_push    = w_hs & (cmd_data != 4'h0) & ~flush;

   assign pulse_out  = r_pulse;
   assign credits    = r_cred;
   assign err_zero   = r_ez;
   assign err_credit = r_ec;
   assign busy       = ~w_empty | (r_pulse != 4'h0) | (r_state == ST_GAP);

   // Next-state logic: decide issue in READY, count down the idle gap in GAP.
   always_comb begin
      w_state_nxt = r_state;
      w_gapc_nxt  = r_gapc;
      w_issue     = 1'b0;
      case (r_state)
         ST_READY: begin
            if (!w_empty && (r_cred != 8'd0) && !flush) begin
               w_issue = 1'b1;
               if (GAP > 0) begin
                  w_state_nxt = ST_GAP;
                  w_gapc_nxt  = GAP_LD;
               end
            end
         end
         ST_GAP: begin
            w_gapc_nxt = r_gapc - 4'd1;
            if (r_gapc <= 4'd1) begin
               w_state_nxt = ST_READY;
               w_gapc_nxt  = 4'd0;
            end
         end
         default: begin
            w_state_nxt = ST_READY;
            w_gapc_nxt  = 4'd0;
         end
      endcase
   end

   // FSM state and gap counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_READY;
         r_gapc  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_gapc  <= w_gapc_nxt;
      end
   end

   // Queue storage; contents are don't-care until the pointers cover them.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= cmd_data;
   end

   // Queue pointers and occupancy; flush drops everything including a same-cycle push.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_rptr  <= r_wptr;
         r_count <= '0;
      end else begin
         if (w_push)  r_wptr <= r_wptr + PTR_ONE;
         if (w_issue) r_rptr <= r_rptr + PTR_ONE;
         case ({w_push, w_issue})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Output pulse register: head of queue for one cycle on issue, else idle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_pulse <= 4'h0;
      else         r_pulse <= w_issue ? r_mem[r_rptr] : 4'h0;
   end

   // Credit counter; a return with no room is dropped and flagged.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cred <= CRED_MAX;
      end else begin
         case ({w_issue, credit_ret})
            2'b10:   r_cred <= r_cred - 8'd1;
            2'b01:   if (r_cred != CRED_MAX) r_cred <= r_cred + 8'd1;
            default: r_cred <= r_cred;
         endcase
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ez <= 1'b0;
         r_ec <= 1'b0;
      end else begin
         if (w_hs && (cmd_data == 4'h0)) r_ez <= 1'b1;
         if (credit_ret && !w_issue && (r_cred == CRED_MAX)) r_ec <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mf_disp_cmd_tx.sv
// Bench for mf_disp_cmd_tx: two instances (GAP=1/CREDITS=16 and GAP=0/CREDITS=2)
// share one stimulus stream; a queue-based reference model predicts every output.
module tb_mf_disp_cmd_tx;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_data = 4'h0;
   logic       flush = 1'b0;
   logic       credit_ret = 1'b0;

   logic       o_ready [2];
   logic [3:0] o_pulse [2];
   logic [7:0] o_cred  [2];
   logic       o_busy  [2];
   logic       o_ez    [2];
   logic       o_ec    [2];

   int nchk = 0;
   int nerr = 0;

   // reference model state
   logic [3:0] m_q [2][$];
   int         m_cred  [2];
   int         m_gapc  [2];
   logic [3:0] m_pulse [2];
   bit         m_ez    [2];
   bit         m_ec    [2];

   always #5 clk = ~clk;

   mf_disp_cmd_tx #(.DEPTH(DEPTH), .CREDITS(16), .GAP(1)) u_a (
      .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .cmd_ready(o_ready[0]), .flush(flush), .credit_ret(credit_ret),
      .pulse_out(o_pulse[0]), .credits(o_cred[0]), .busy(o_busy[0]),
      .err_zero(o_ez[0]), .err_credit(o_ec[0]));

   mf_disp_cmd_tx #(.DEPTH(DEPTH), .CREDITS(2), .GAP(0)) u_b (
      .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .cmd_ready(o_ready[1]), .flush(flush), .credit_ret(credit_ret),
      .pulse_out(o_pulse[1]), .credits(o_cred[1]), .busy(o_busy[1]),
      .err_zero(o_ez[1]), .err_credit(o_ec[1]));

   function automatic int cr(int i);
      return (i == 0) ? 16 : 2;
   endfunction

   function automatic int gp(int i);
      return (i == 0) ? 1 : 0;
   endfunction

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_q[i].delete();
         m_cred[i]  = cr(i);
         m_gapc[i]  = 0;
         m_pulse[i] = 4'h0;
         m_ez[i]    = 1'b0;
         m_ec[i]    = 1'b0;
      end
   endtask

   // One clock edge of behaviour from the current (pre-edge) inputs.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit rdy, hs, iss;
         rdy = (m_q[i].size() < DEPTH);
         hs  = cmd_valid && rdy;
         iss = (m_gapc[i] == 0) && (m_q[i].size() > 0) && (m_cred[i] > 0) && !flush;
         if (hs && cmd_data == 4'h0) m_ez[i] = 1'b1;
         if (m_gapc[i] > 0) m_gapc[i]--;
         else if (iss)      m_gapc[i] = gp(i);
         m_pulse[i] = iss ? m_q[i].pop_front() : 4'h0;
         if (flush) m_q[i].delete();
         else if (hs && cmd_data != 4'h0) m_q[i].push_back(cmd_data);
         if (iss && !credit_ret) m_cred[i]--;
         else if (!iss && credit_ret) begin
            if (m_cred[i] == cr(i)) m_ec[i] = 1'b1;
            else                    m_cred[i]++;
         end
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < 2; i++) begin
         bit busy_e;
         busy_e = (m_q[i].size() > 0) || (m_pulse[i] != 4'h0) || (m_gapc[i] > 0);
         chk($sformatf("pulse[%0d]", i), 8'(o_pulse[i]), 8'(m_pulse[i]));
         chk($sformatf("credits[%0d]", i), o_cred[i], 8'(m_cred[i]));
         chk($sformatf("ready[%0d]", i), 8'(o_ready[i]), 8'(m_q[i].size() < DEPTH));
         chk($sformatf("busy[%0d]", i), 8'(o_busy[i]), 8'(busy_e));
         chk($sformatf("err_zero[%0d]", i), 8'(o_ez[i]), 8'(m_ez[i]));
         chk($sformatf("err_credit[%0d]", i), 8'(o_ec[i]), 8'(m_ec[i]));
      end
   endtask

   // Advance one clock: model sees the same inputs the DUT samples; compare on negedge.
   task automatic cyc();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   initial begin
      logic [3:0] d [4];
      logic [3:0] x;

      // reset state
      model_reset();
      repeat (3) @(negedge clk);
      check_model();
      chk("rst_ready", 8'(o_ready[0]), 8'h1);
      chk("rst_credits", o_cred[0], 8'd16);
      chk("rst_pulse", 8'(o_pulse[0]), 8'h0);
      resetn = 1'b1;
      idle(2);

      // T1: 3 then 5 back-to-back, GAP=1
      cmd_valid = 1'b1; cmd_data = 4'h3; cyc();
      cmd_data = 4'h5; cyc();
      chk("t1_first", 8'(o_pulse[0]), 8'h3);
      cmd_valid = 1'b0; cmd_data = 4'h0; cyc();
      chk("t1_gap", 8'(o_pulse[0]), 8'h0);
      cyc();
      chk("t1_second", 8'(o_pulse[0]), 8'h5);
      chk("t1_credits", o_cred[0], 8'd14);
      cyc();
      chk("t1_busy_low", 8'(o_busy[0]), 8'h0);

      // T2: GAP=0, CREDITS=2 instance; refill its credits first
      credit_ret = 1'b1; idle(2); credit_ret = 1'b0;
      chk("t2_refill", o_cred[1], 8'd2);
      cmd_valid = 1'b1; cmd_data = 4'hA; cyc();
      cmd_data = 4'hB; cyc();
      chk("t2_A", 8'(o_pulse[1]), 8'hA);
      cmd_data = 4'hC; cyc();
      chk("t2_B", 8'(o_pulse[1]), 8'hB);
      chk("t2_cred0", o_cred[1], 8'd0);
      cmd_valid = 1'b0; cmd_data = 4'h0; idle(2);
      chk("t2_stall_pulse", 8'(o_pulse[1]), 8'h0);
      chk("t2_stall_busy", 8'(o_busy[1]), 8'h1);
      credit_ret = 1'b1; cyc();
      credit_ret = 1'b0;
      chk("t2_ret_plus1", 8'(o_pulse[1]), 8'h0);
      cyc();
      chk("t2_C", 8'(o_pulse[1]), 8'hC);
      chk("t2_cred_after", o_cred[1], 8'd0);

      // T3: fill the credit-starved queue
      for (int k = 0; k < 4; k++) d[k] = 4'($urandom_range(1, 15));
      cmd_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin cmd_data = d[k]; cyc(); end
      cmd_valid = 1'b0; cmd_data = 4'h0;
      chk("t3_full", 8'(o_ready[1]), 8'h0);
      credit_ret = 1'b1; cyc();
      credit_ret = 1'b0;
      chk("t3_still_full", 8'(o_ready[1]), 8'h0);
      cyc();
      chk("t3_ready_back", 8'(o_ready[1]), 8'h1);
      chk("t3_head", 8'(o_pulse[1]), 8'(d[0]));
      credit_ret = 1'b1; idle(3); credit_ret = 1'b0;
      idle(8);

      // T4: zero command and excess credit return
      cmd_valid = 1'b1; cmd_data = 4'h0; cyc();
      cmd_valid = 1'b0; cyc();
      chk("t4_ez", 8'(o_ez[0]), 8'h1);
      chk("t4_nopulse", 8'(o_pulse[0]), 8'h0);
      idle(3);
      chk("t4_ez_sticky", 8'(o_ez[0]), 8'h1);
      credit_ret = 1'b1; idle(5); credit_ret = 1'b0; cyc();
      chk("t4_cred_max", o_cred[0], 8'd16);
      chk("t4_ec", 8'(o_ec[0]), 8'h1);

      // T5: drain to 5 credits, then issue with a same-cycle return
      for (int k = 0; k < 11; k++) begin
         cmd_valid = 1'b1; cmd_data = 4'($urandom_range(1, 15)); cyc();
         cmd_valid = 1'b0; cyc();
      end
      chk("t5_cred5", o_cred[0], 8'd5);
      x = 4'($urandom_range(1, 15));
      cmd_valid = 1'b1; cmd_data = x; cyc();
      cmd_valid = 1'b0; credit_ret = 1'b1; cyc();
      credit_ret = 1'b0;
      chk("t5_pulse", 8'(o_pulse[0]), 8'(x));
      chk("t5_cred_same", o_cred[0], 8'd5);
      idle(2);
      cmd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin cmd_data = 4'($urandom_range(1, 15)); cyc(); end
      cmd_valid = 1'b0; cmd_data = 4'h0; flush = 1'b1; cyc();
      flush = 1'b0;
      chk("t5_flush_busy", 8'(o_busy[0]), 8'h0);
      idle(4);
      chk("t5_flush_nopulse", 8'(o_pulse[0]), 8'h0);
      chk("t5_flush_cred", o_cred[0], 8'd3);

      // T6: async reset in the middle of a gap with commands queued
      cmd_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin cmd_data = 4'($urandom_range(1, 15)); cyc(); end
      cmd_valid = 1'b0; cmd_data = 4'h0;
      chk("t6_pre_busy", 8'(o_busy[0]), 8'h1);
      #2 resetn = 1'b0;
      model_reset();
      #1;
      chk("t6_pulse_cut", 8'(o_pulse[0]), 8'h0);
      chk("t6_cred_rst", o_cred[0], 8'd16);
      check_model();
      @(negedge clk);
      resetn = 1'b1;
      idle(4);
      chk("t6_no_pulse", 8'(o_pulse[0]), 8'h0);
      chk("t6_idle", 8'(o_busy[0]), 8'h0);

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         cmd_valid  = ($urandom_range(0, 3) != 0);
         cmd_data   = 4'($urandom_range(0, 15));
         credit_ret = ($urandom_range(0, 2) == 0);
         flush      = ($urandom_range(0, 31) == 0);
         cyc();
      end
      cmd_valid = 1'b0; credit_ret = 1'b0; flush = 1'b0;
      idle(4);

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
